// File: rtl/snail_pkg.sv
// Shared constants and the prefix/suffix fallback function for the snail sequence detector.
package snail_pkg;
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int RST_STATE = 0;

  // Pattern is right-aligned in pat; received-bit index i lives at pat[pat_w-1-i].
  // Returns the longest k (k < pat_w) such that the first k pattern bits equal the
  // last k bits of (first len pattern bits, then d). Covers advance, KMP fallback and
  // the overlapping-hit border in one search.
  function automatic logic [4:0] kmp_next(input logic [PAT_W_MAX-1:0] pat,
                                          input int pat_w, input int len,
                                          input logic d);
    int kmax, best, si;
    logic ok, pb, sb;
    logic [3:0] idx;
    kmax = (len + 1 < pat_w - 1) ? len + 1 : pat_w - 1;
    best = 0;
    for (int k = 1; k <= PAT_W_MAX; k++) begin
      if (k <= kmax) begin
        ok = 1'b1;
        for (int j = 0; j < PAT_W_MAX; j++) begin
          if (j < k) begin
            idx = 4'(pat_w - 1 - j);
            pb  = pat[idx];
            si  = len + 1 - k + j;
            idx = 4'(pat_w - 1 - si);
            sb  = (si < len) ? pat[idx] : d;
            if (pb != sb) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return 5'(best);
  endfunction
endpackage

// File: rtl/snail_hit_counter.sv
// Saturating hit counter; a clear wins over a simultaneous increment.
module snail_hit_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst)                   cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && cnt != '1)   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/snail_seq_detector.sv
// Programmable serial pattern detector with KMP fallback and overlap control.
// Define SNAIL_HIT_COUNTER_EN to build the saturating hit counter.
module snail_seq_detector
  import snail_pkg::*;
#(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1011,
  parameter int               CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     _rst,
  input  logic                     en,
  input  logic                     D,
  input  logic                     overlap,
  input  logic                     pat_load,
  input  logic [PAT_W-1:0]         pat_in,
  input  logic                     clr,
  output logic                     Q,
  output logic [$clog2(PAT_W)-1:0] match_len,
  output logic [CNT_W-1:0]         hit_cnt
);
  localparam int SW = $clog2(PAT_W);

  logic [PAT_W-1:0] pat_q;
  logic [SW-1:0]    state;
  logic             cur_bit;
  logic             hit;
  logic [SW-1:0]    nxt;

  assign cur_bit = pat_q[SW'(PAT_W - 1) - state];
  assign hit     = en && !pat_load && (D == cur_bit) && (state == SW'(PAT_W - 1));
  assign nxt     = (hit && !overlap) ? SW'(RST_STATE)
                 : SW'(kmp_next(PAT_W_MAX'(pat_q), PAT_W, int'(state), D));

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      pat_q <= PAT_INIT;
      state <= SW'(RST_STATE);
      Q     <= 1'b0;
    end else if (pat_load) begin
      pat_q <= pat_in;
      state <= SW'(RST_STATE);
      Q     <= 1'b0;
    end else if (en) begin
      state <= nxt;
      Q     <= hit;
    end else begin
      Q     <= 1'b0;
    end
  end

  assign match_len = state;

`ifdef SNAIL_HIT_COUNTER_EN
  snail_hit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    ._rst(_rst),
    .clr (clr),
    .inc (hit),
    .cnt (hit_cnt)
  );
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign hit_cnt    = '0;
`endif
endmodule

// File: tb/tb_snail_seq_detector.sv
// Directed bench: two detectors (CNT_W=8 and CNT_W=2) share one stimulus stream.
module tb_snail_seq_detector;
`ifdef SNAIL_HIT_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       _rst;
  logic       en, D, overlap, pat_load, clr;
  logic [3:0] pat_in;
  logic       q8, q2;
  logic [1:0] ml8, ml2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  snail_seq_detector u8 (
    .clk(clk), ._rst(_rst), .en(en), .D(D), .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .clr(clr), .Q(q8), .match_len(ml8), .hit_cnt(cnt8)
  );

  snail_seq_detector #(.CNT_W(2)) u2 (
    .clk(clk), ._rst(_rst), .en(en), .D(D), .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .clr(clr), .Q(q2), .match_len(ml2), .hit_cnt(cnt2)
  );

  function automatic logic [31:0] ec(input int v);
    return CNT_ON ? 32'(v) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic e);
    D = d; en = e;
    @(posedge clk); #1;
  endtask

  task automatic st(input string tag, input int q, input int ml);
    chk({tag, ".Q"}, 32'(q8), 32'(q));
    chk({tag, ".ml"}, 32'(ml8), 32'(ml));
    chk({tag, ".Q2"}, 32'(q2), 32'(q));
  endtask

  task automatic cnts(input string tag, input int c8, input int c2);
    chk({tag, ".cnt8"}, 32'(cnt8), ec(c8));
    chk({tag, ".cnt2"}, 32'(cnt2), ec(c2));
  endtask

  task automatic do_reset();
    _rst = 1'b0; #2; _rst = 1'b1;
  endtask

  initial begin
    logic [6:0] s7;
    int eq [7];
    int eml[7];
    _rst = 1'b0; en = 1'b0; D = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000; clr = 1'b0;
    #2;
    st("rst", 0, 0);
    cnts("rst", 0, 0);
    @(negedge clk); _rst = 1'b1;
    @(posedge clk); #1;

    // overlapping: 1011011 -> hits after bits 4 and 7
    s7 = 7'b1011011;
    eml = '{1, 2, 3, 1, 2, 3, 1};
    eq  = '{0, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      step(s7[6-i], 1'b1);
      st($sformatf("ovl%0d", i), eq[i], eml[i]);
    end
    cnts("ovl", 2, 2);

    // non-overlapping: same stream, single hit
    do_reset(); overlap = 1'b0;
    eml = '{1, 2, 3, 0, 0, 1, 1};
    eq  = '{0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      step(s7[6-i], 1'b1);
      st($sformatf("novl%0d", i), eq[i], eml[i]);
    end
    cnts("novl", 1, 1);

    // en=0 holds state
    do_reset(); overlap = 1'b1;
    step(1, 1); step(0, 1); step(1, 1);
    st("en.pre", 0, 3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      st($sformatf("en.hold%0d", i), 0, 3);
    end
    step(1, 1); st("en.hit", 1, 1);
    step(1, 0); st("en.after", 0, 1);
    cnts("en", 1, 1);

    // pattern load mid-match
    do_reset();
    step(1, 1); step(0, 1);
    st("ld.pre", 0, 2);
    pat_load = 1'b1; pat_in = 4'b0110;
    step(1, 1); st("ld", 0, 0);
    pat_load = 1'b0;
    step(0, 1); st("ld.b0", 0, 1);
    step(1, 1); st("ld.b1", 0, 2);
    step(1, 1); st("ld.b2", 0, 3);
    step(0, 1); st("ld.hit", 1, 1);
    step(1, 1); st("ld.c1", 0, 2);
    step(1, 1); st("ld.c2", 0, 3);
    step(1, 1); st("ld.fb", 0, 0);
    cnts("ld", 1, 1);

    // saturation and clr vs hit (pattern back to 1011 after reset)
    do_reset();
    step(1, 1); step(0, 1); step(1, 1); step(1, 1);
    st("sat.h1", 1, 1);
    for (int h = 0; h < 4; h++) begin
      step(0, 1); step(1, 1); step(1, 1);
    end
    st("sat.h5", 1, 1);
    cnts("sat", 5, 3);
    step(0, 1); step(1, 1);
    clr = 1'b1;
    step(1, 1);
    clr = 1'b0;
    st("clr.h6", 1, 1);
    cnts("clr", 0, 0);
    step(0, 1); step(1, 1); step(1, 1);
    cnts("clr.h7", 1, 1);

    // async reset mid-match
    do_reset();
    step(1, 1); step(0, 1); step(1, 1); step(1, 1);
    step(0, 1); step(1, 1);
    st("ar.pre", 0, 3);
    cnts("ar.pre", 1, 1);
    #2; _rst = 1'b0; #1;
    st("ar.low", 0, 0);
    cnts("ar.low", 0, 0);
    #1; _rst = 1'b1;
    step(1, 1); st("ar.disc", 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
